life_engine: RTL and testbench

Generation engine for the Game of Life board. It sweeps the current-generation buffer through the logic-side read port of the double buffer and computes the B3/S23 next state one memory word at a time. Each result word goes out through the logic-side write port, and the block pulses the buffer swap when the last word is written. It sits between the frame/step timer, which supplies `start_in`, and the double buffer.

---
 rtl/life_pkg.sv | 23 ++
 rtl/life_word_rule.sv | 42 ++++
 rtl/life_engine.sv | 219 +++++++++++++++++++++
 tb/tb_life_engine.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game of Life generation engine.
package life_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_SWAP  = 3'd4
    } life_state_t;

    // B3/S23 rule
    localparam int unsigned BIRTH_COUNT   = 3;
    localparam int unsigned SURVIVE_COUNT = 2;

    // Neighbour count 0..8
    localparam int unsigned NCOUNT_W = 4;

    // PRIME/FETCH run three read phases plus one drain phase
    localparam int unsigned PHASE_W    = 2;
    localparam logic [PHASE_W-1:0] LAST_PHASE = 2'd3;

endpackage

// File: rtl/life_word_rule.sv
// Next-state of one memory word from a 3x3 window of words (rows r-1..r+1, columns c-1..c+1).
module life_word_rule
    import life_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = 8
) (
    input  logic [2:0][2:0][LINE_WIDTH-1:0] win,
    output logic [LINE_WIDTH-1:0]           next_word_c
);

    logic [2:0][3*LINE_WIDTH-1:0] row_ext;
    logic [NCOUNT_W-1:0]          n;
    logic                         alive;

    // Flatten each window row; bit LINE_WIDTH+x is cell x of column c
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_ext[r] = {win[r][2], win[r][1], win[r][0]};
        end
    end

    // Count the eight neighbours of every cell and apply the rule
    always_comb begin
        n           = '0;
        alive       = 1'b0;
        next_word_c = '0;
        for (int x = 0; x < int'(LINE_WIDTH); x++) begin
            n = '0;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    if (!(r == 1 && k == 1)) begin
                        n = n + NCOUNT_W'(row_ext[r][x + k + int'(LINE_WIDTH) - 1]);
                    end
                end
            end
            alive = row_ext[1][x + int'(LINE_WIDTH)];
            next_word_c[x] = (n == NCOUNT_W'(BIRTH_COUNT)) ||
                             (alive && (n == NCOUNT_W'(SURVIVE_COUNT)));
        end
    end

endmodule

// File: rtl/life_engine.sv
// Sweeps the current generation word by word, writes the B3/S23 next state and pulses the buffer swap.
module life_engine
    import life_pkg::*;
#(
    parameter int unsigned ADDR_SIZE     = 32,
    parameter int unsigned LINE_WIDTH    = 8,
    parameter int unsigned WORDS_PER_ROW = 40,
    parameter int unsigned ROWS          = 240
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    output logic [ADDR_SIZE-1:0]  addr_r_out,
    input  logic [LINE_WIDTH-1:0] data_r_in,
    output logic [ADDR_SIZE-1:0]  addr_w_out,
    output logic [LINE_WIDTH-1:0] data_w_out,
    output logic                  we_out,
    output logic                  swap_out,
    output logic                  busy_out
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [ROW_W-1:0]     LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]     LAST_COL   = COL_W'(WORDS_PER_ROW - 1);
    localparam logic [ADDR_SIZE-1:0] ROW_STRIDE = ADDR_SIZE'(WORDS_PER_ROW);

    life_state_t          state, state_nxt;
    logic [PHASE_W-1:0]   phase, phase_nxt;
    logic [ROW_W-1:0]     row, row_nxt;
    logic [COL_W-1:0]     col, col_nxt;
    logic [ADDR_SIZE-1:0] row_base, row_base_nxt;

    // Read in flight this cycle (rd_*) and read whose data arrives this cycle (cap_*)
    logic       rd_pend, rd_ok, cap_pend, cap_ok;
    logic [1:0] rd_slot, rd_col, cap_slot, cap_col;

    logic                  rd_pend_nxt, rd_ok_nxt, row_ok, col_ok;
    logic [1:0]            rd_slot_nxt, rd_col_nxt;
    logic [ADDR_SIZE-1:0]  rd_base, rd_col_idx, addr_r_nxt, addr_w_nxt;
    logic [LINE_WIDTH-1:0] data_w_nxt, rule_word;
    logic                  we_nxt, swap_nxt, busy_nxt;

    logic [2:0][2:0][LINE_WIDTH-1:0] win, win_nxt;

    // FSM state and sweep counters
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            phase    <= '0;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            row_base <= row_base_nxt;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        row_nxt      = row;
        col_nxt      = col;
        row_base_nxt = row_base;
        unique case (state)
            ST_IDLE: begin
                if (start_in) begin
                    state_nxt    = ST_PRIME;
                    phase_nxt    = '0;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    row_base_nxt = '0;
                end
            end
            ST_PRIME, ST_FETCH: begin
                if (phase == LAST_PHASE) begin
                    state_nxt = (state == ST_PRIME) ? ST_FETCH : ST_WRITE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + PHASE_W'(1);
                end
            end
            ST_WRITE: begin
                phase_nxt = '0;
                if (col != LAST_COL) begin
                    col_nxt   = col + COL_W'(1);
                    state_nxt = ST_FETCH;
                end else if (row != LAST_ROW) begin
                    row_nxt      = row + ROW_W'(1);
                    col_nxt      = '0;
                    row_base_nxt = row_base + ROW_STRIDE;
                    state_nxt    = ST_PRIME;
                end else begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_SWAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs: read address of the coming phase, write strobe, swap, busy
    always_comb begin
        rd_pend_nxt = 1'b0;
        rd_ok_nxt   = 1'b0;
        rd_slot_nxt = phase_nxt;
        rd_col_nxt  = 2'd1;
        rd_base     = row_base_nxt;
        rd_col_idx  = ADDR_SIZE'(col_nxt);
        row_ok      = 1'b1;
        col_ok      = 1'b1;
        addr_r_nxt  = '0;
        we_nxt      = (state_nxt == ST_WRITE);
        addr_w_nxt  = we_nxt ? (row_base_nxt + ADDR_SIZE'(col_nxt)) : '0;
        data_w_nxt  = we_nxt ? rule_word : '0;
        swap_nxt    = (state_nxt == ST_SWAP);
        busy_nxt    = (state_nxt != ST_IDLE);
        if ((state_nxt == ST_PRIME || state_nxt == ST_FETCH) && phase_nxt != LAST_PHASE) begin
            rd_pend_nxt = 1'b1;
            if (state_nxt == ST_FETCH) begin
                rd_col_nxt = 2'd2;
                rd_col_idx = ADDR_SIZE'(col_nxt) + ADDR_SIZE'(1);
                col_ok     = (col_nxt != LAST_COL);
            end
            case (phase_nxt)
                2'd0: begin
                    rd_base = row_base_nxt - ROW_STRIDE;
                    row_ok  = (row_nxt != '0);
                end
                2'd2: begin
                    rd_base = row_base_nxt + ROW_STRIDE;
                    row_ok  = (row_nxt != LAST_ROW);
                end
                default: begin
                    rd_base = row_base_nxt;
                end
            endcase
            rd_ok_nxt = row_ok && col_ok;
            if (rd_ok_nxt) begin
                addr_r_nxt = rd_base + rd_col_idx;
            end
        end
    end

    // Window update: clear left column at row start, land read data, shift left after a write
    always_comb begin
        win_nxt = win;
        if (state == ST_PRIME && phase == '0) begin
            for (int i = 0; i < 3; i++) begin
                win_nxt[i][0] = '0;
            end
        end
        if (cap_pend) begin
            win_nxt[cap_slot][cap_col] = cap_ok ? data_r_in : '0;
        end
        if (state == ST_WRITE) begin
            for (int i = 0; i < 3; i++) begin
                win_nxt[i][0] = win[i][1];
                win_nxt[i][1] = win[i][2];
                win_nxt[i][2] = '0;
            end
        end
    end

    // Rule evaluated on the window as it will stand in the WRITE cycle
    life_word_rule #(
        .LINE_WIDTH (LINE_WIDTH)
    ) u_rule (
        .win         (win_nxt),
        .next_word_c (rule_word)
    );

    // Window, read tracking and output registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            addr_r_out <= '0;
            addr_w_out <= '0;
            data_w_out <= '0;
            we_out     <= 1'b0;
            swap_out   <= 1'b0;
            busy_out   <= 1'b0;
            rd_pend    <= 1'b0;
            rd_ok      <= 1'b0;
            rd_slot    <= '0;
            rd_col     <= '0;
            cap_pend   <= 1'b0;
            cap_ok     <= 1'b0;
            cap_slot   <= '0;
            cap_col    <= '0;
            win        <= '0;
        end else begin
            addr_r_out <= addr_r_nxt;
            addr_w_out <= addr_w_nxt;
            data_w_out <= data_w_nxt;
            we_out     <= we_nxt;
            swap_out   <= swap_nxt;
            busy_out   <= busy_nxt;
            rd_pend    <= rd_pend_nxt;
            rd_ok      <= rd_ok_nxt;
            rd_slot    <= rd_slot_nxt;
            rd_col     <= rd_col_nxt;
            cap_pend   <= rd_pend;
            cap_ok     <= rd_ok;
            cap_slot   <= rd_slot;
            cap_col    <= rd_col;
            win        <= win_nxt;
        end
    end

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine on a 16x4 board: scoreboard of expected writes, cycle timing, abort.
`timescale 1ns/1ps
module tb_life_engine;

    localparam int AW  = 32;
    localparam int LW  = 8;
    localparam int W   = 2;
    localparam int NR  = 4;
    localparam int NW  = W * NR;
    localparam int BW  = W * LW;
    localparam int GEN = NR * (4 + 5 * W) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
    } wr_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] addr_r_out;
    logic [LW-1:0] data_r_in = '0;
    logic [AW-1:0] addr_w_out;
    logic [LW-1:0] data_w_out;
    logic          we_out;
    logic          swap_out;
    logic          busy_out;

    logic [LW-1:0] mem   [NW];
    logic [LW-1:0] exp_w [NW];
    wr_t           sb_q  [$];
    int            checks  = 0;
    int            errors  = 0;
    int            we_seen = 0;

    wire [74:0] outs = {addr_r_out, addr_w_out, data_w_out, we_out, swap_out, busy_out};

    life_engine #(
        .ADDR_SIZE     (AW),
        .LINE_WIDTH    (LW),
        .WORDS_PER_ROW (W),
        .ROWS          (NR)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .addr_r_out (addr_r_out),
        .data_r_in  (data_r_in),
        .addr_w_out (addr_w_out),
        .data_w_out (data_w_out),
        .we_out     (we_out),
        .swap_out   (swap_out),
        .busy_out   (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Current-generation buffer: data one cycle after the address
    always @(posedge clk_in) begin
        data_r_in <= (addr_r_out < AW'(NW)) ? mem[addr_r_out[$clog2(NW)-1:0]] : '0;
    end

    // Write monitor: pop the expected write and compare address and data
    always @(negedge clk_in) begin
        if (!rst_in && we_out) begin
            we_seen++;
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr=%0d data=0x%0h, required no write", addr_w_out, data_w_out);
            end
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                checks++;
                assert ({addr_w_out, data_w_out} === {e.addr, e.data}) else begin
                    errors++;
                    $error("FAIL write_word: observed addr=%0d data=0x%0h, required addr=%0d data=0x%0h", addr_w_out, data_w_out, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h required=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic cell_at(input int r, input int x);
        logic [LW-1:0] w;
        if (r < 0 || r >= NR || x < 0 || x >= BW) return 1'b0;
        w = mem[r * W + x / LW];
        return w[x % LW];
    endfunction

    // Cell-level reference: dead border, B3/S23
    task automatic compute_expected();
        int  n;
        logic nb;
        for (int r = 0; r < NR; r++) begin
            for (int x = 0; x < BW; x++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (!(dr == 0 && dx == 0)) n += int'(cell_at(r + dr, x + dx));
                    end
                end
                nb = (n == 3) || (cell_at(r, x) && n == 2);
                exp_w[r * W + x / LW][x % LW] = nb;
            end
        end
    endtask

    task automatic clear_boards();
        for (int i = 0; i < NW; i++) begin
            mem[i]   = '0;
            exp_w[i] = '0;
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < NW; i++) begin
            sb_q.push_back('{addr: AW'(i), data: exp_w[i]});
        end
    endtask

    // One full generation with timing checks; optionally pokes start_in while busy
    task automatic run_gen(input string tag, input bit poke_busy);
        int   swap_k   = 0;
        int   swap_cnt = 0;
        int   we0;
        logic busy1    = 1'b0;
        logic busy_end = 1'b0;
        logic busy_aft = 1'b1;
        push_expected();
        we0 = we_seen;
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        for (int k = 1; k <= 130; k++) begin
            if (k == 1)       busy1    = busy_out;
            if (k == GEN)     busy_end = busy_out;
            if (k == GEN + 1) busy_aft = busy_out;
            if (swap_out) begin
                swap_cnt++;
                if (swap_k == 0) swap_k = k;
            end
            start_in = (poke_busy && k == 30);
            @(negedge clk_in);
        end
        start_in = 1'b0;
        check({tag, "_busy_rise"},  96'(busy1), 96'(1));
        check({tag, "_swap_cycle"}, 96'(swap_k), 96'(GEN));
        check({tag, "_swap_count"}, 96'(swap_cnt), 96'(1));
        check({tag, "_busy_swap"},  96'(busy_end), 96'(1));
        check({tag, "_busy_fall"},  96'(busy_aft), 96'(0));
        check({tag, "_we_count"},   96'(we_seen - we0), 96'(NW));
        check({tag, "_sb_empty"},   96'(sb_q.size()), 96'(0));
    endtask

    initial begin
        int we0;
        int swap_cnt;
        rst_in   = 1'b1;
        start_in = 1'b0;
        clear_boards();

        // Reset held: a start pulse must not wake the engine
        repeat (3) @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        check("reset_outputs", 96'(outs), 96'(0));
        repeat (3) @(negedge clk_in);
        check("reset_hold_after_start", 96'(outs), 96'(0));
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("idle_after_release", 96'(outs), 96'(0));

        // Blinker turns vertical in column 2
        clear_boards();
        mem[2] = 8'h0E;
        exp_w[0] = 8'h04;
        exp_w[2] = 8'h04;
        exp_w[4] = 8'h04;
        run_gen("blinker", 1'b1);

        // 2x2 block straddling the word boundary is a still life
        clear_boards();
        mem[2] = 8'h80; mem[4] = 8'h80;
        mem[3] = 8'h01; mem[5] = 8'h01;
        for (int i = 0; i < NW; i++) exp_w[i] = mem[i];
        run_gen("cross_block", 1'b0);

        // Full board: only the four corners survive against the dead border
        clear_boards();
        for (int i = 0; i < NW; i++) mem[i] = 8'hFF;
        exp_w[0] = 8'h01; exp_w[6] = 8'h01;
        exp_w[1] = 8'h80; exp_w[7] = 8'h80;
        run_gen("dead_boundary", 1'b0);

        // Random boards against the cell-level model
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < NW; i++) mem[i] = LW'($urandom);
            compute_expected();
            run_gen($sformatf("random%0d", g), 1'b0);
        end

        // Abort at cycle 20: async clear mid-cycle, no swap, no further writes
        for (int i = 0; i < NW; i++) mem[i] = LW'($urandom);
        compute_expected();
        push_expected();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (19) @(negedge clk_in);
        check("abort_busy_before", 96'(busy_out), 96'(1));
        #1 rst_in = 1'b1;
        #1 check("abort_async_clear", 96'(outs), 96'(0));
        sb_q.delete();
        we0 = we_seen;
        swap_cnt = 0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (swap_out) swap_cnt++;
            @(negedge clk_in);
        end
        check("abort_no_swap", 96'(swap_cnt), 96'(0));
        check("abort_no_write", 96'(we_seen - we0), 96'(0));
        run_gen("after_abort", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
